// File: rtl/bus_dest_ctrl.sv
// Destination side of the shared 8-bit bus: owns registers a..f, drives the mux select,
// and moves one register into another through the bus under a req/busy/done handshake.
module bus_dest_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [2:0]       src,
    input  logic [2:0]       dst,
    input  logic             ld_en,
    input  logic [2:0]       ld_sel,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [WIDTH-1:0] bus_in,
    output logic             S0,
    output logic             S1,
    output logic             S2,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] LOAD   = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] MAX_CODE = 3'd5;

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d;
    logic [2:0]       dst_q, dst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] regs_q [6];
    logic [WIDTH-1:0] regs_d [6];

    logic req_ok;
    logic req_bad;
    logic ld_ok;
    logic ld_bad;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        dst_d   = dst_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        regs_d  = regs_q;
        req_ok  = req && (src <= MAX_CODE) && (dst <= MAX_CODE);
        req_bad = 1'b0;
        // Loads are only legal while no transfer owns the registers.
        ld_ok   = ld_en && !busy_q && (ld_sel <= MAX_CODE);
        ld_bad  = ld_en && (busy_q || (ld_sel > MAX_CODE));

        case (state_q)
            IDLE: begin
                if (req_ok) begin
                    state_d = SETTLE;
                    sel_d   = src;
                    dst_d   = dst;
                    cnt_d   = CNT_INIT;
                    busy_d  = 1'b1;
                end else if (req) begin
                    req_bad = 1'b1;
                end
            end
            SETTLE: begin
                busy_d = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            LOAD: begin
                regs_d[dst_q] = bus_in;
                state_d       = IDLE;
                done_d        = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A same-cycle transfer captures later, so this write is seen by it.
        if (ld_ok) begin
            regs_d[ld_sel] = ld_data;
        end

        err_d = req_bad || ld_bad;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            sel_q   <= 3'd0;
            dst_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            dst_q   <= dst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            for (int i = 0; i < 6; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign {S2, S1, S0} = sel_q;
    assign a         = regs_q[0];
    assign b         = regs_q[1];
    assign c         = regs_q[2];
    assign d         = regs_q[3];
    assign e         = regs_q[4];
    assign f         = regs_q[5];
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule
